// File: rtl/paddle_ctrl_v2.sv
// paddle_ctrl_v2: parametrised paddle position controller.
// Holds the paddle left edge and length and drives them to the collision and
// draw logic. Supports absolute positioning and a tick-divided relative mode
// with optional acceleration. Every position result is clamped to the playfield.
module paddle_ctrl_v2 #(
    parameter int X_WIDTH   = 8,
    parameter int SCREEN_W  = 160,
    parameter int DEF_LEN   = 20,
    parameter int MIN_LEN   = 4,
    parameter int MAX_LEN   = 40,
    parameter int TICK_DIV  = 4,
    parameter int MAX_SPEED = 4,
    parameter int ACCEL_EN  = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2:0]         game_state,
    input  logic               mode,
    input  logic               in_enable,
    input  logic [X_WIDTH-1:0] abs_x,
    input  logic               move_left,
    input  logic               move_right,
    input  logic [X_WIDTH-1:0] length_req,
    input  logic               length_load,
    output logic [X_WIDTH-1:0] paddle_x,
    output logic [X_WIDTH-1:0] paddle_len,
    output logic [2:0]         speed,
    output logic               at_left,
    output logic               at_right,
    output logic               moved
);

    // Tick counter needs at least one bit even when every cycle is a tick.
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [X_WIDTH:0]   SCREEN_X  = (X_WIDTH+1)'(SCREEN_W);
    localparam logic [X_WIDTH-1:0] DEF_L     = X_WIDTH'(DEF_LEN);
    localparam logic [X_WIDTH-1:0] MIN_L     = X_WIDTH'(MIN_LEN);
    localparam logic [X_WIDTH-1:0] MAX_L     = X_WIDTH'(MAX_LEN);
    localparam logic [X_WIDTH-1:0] RST_X     = X_WIDTH'((SCREEN_W - DEF_LEN) / 2);
    localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [2:0]         MAX_S     = 3'(MAX_SPEED);

    // Decoded game state: unknown codes are treated as PAUSE.
    typedef enum logic [1:0] {GS_IDLE, GS_PLAY, GS_PAUSE} gstate_t;
    // Direction of the previous motion tick; NONE also means "previous tick idle".
    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

    logic [X_WIDTH-1:0] r_x;
    logic [X_WIDTH-1:0] r_len;
    logic [2:0]         r_speed;
    logic [TW-1:0]      r_tick;
    dir_t               r_dir;
    logic               r_moved;

    gstate_t            w_gs;
    logic [X_WIDTH-1:0] w_len_clamped;
    logic [X_WIDTH-1:0] w_len_next;
    logic [X_WIDTH:0]   w_x_max;
    logic [X_WIDTH:0]   w_center;
    logic [X_WIDTH:0]   w_x_cand;
    logic [X_WIDTH:0]   w_x_clamped;
    logic [X_WIDTH-1:0] w_x_next;
    logic [2:0]         w_speed_next;
    logic [2:0]         w_new_speed;
    logic [X_WIDTH:0]   w_speed_ext;
    logic [TW-1:0]      w_tick_next;
    dir_t               w_dir_next;
    dir_t               w_req_dir;
    logic               w_tick;

    // Decode game state and the requested relative direction.
    always_comb begin
        w_gs = GS_PAUSE;
        case (game_state)
            3'b000:  w_gs = GS_IDLE;
            3'b001:  w_gs = GS_PLAY;
            default: w_gs = GS_PAUSE;
        endcase
        w_req_dir = DIR_NONE;
        if (move_left && !move_right)
            w_req_dir = DIR_LEFT;
        else if (move_right && !move_left)
            w_req_dir = DIR_RIGHT;
    end

    // Length update comes first so the position clamp sees the new length.
    always_comb begin
        w_len_clamped = length_req;
        if (length_req < MIN_L)
            w_len_clamped = MIN_L;
        else if (length_req > MAX_L)
            w_len_clamped = MAX_L;
        w_len_next = r_len;
        if (length_load && (w_gs != GS_PAUSE))
            w_len_next = w_len_clamped;
        w_x_max  = SCREEN_X - {1'b0, w_len_next};
        w_center = (SCREEN_X - {1'b0, r_len}) >> 1;
        w_tick   = (r_tick == TICK_LAST);
    end

    // Speed a motion tick would apply, given the previous tick's direction.
    always_comb begin
        w_new_speed = MAX_S;
        if (ACCEL_EN != 0) begin
            if ((w_req_dir == r_dir) && (r_dir != DIR_NONE))
                w_new_speed = (r_speed >= MAX_S) ? MAX_S : (r_speed + 3'd1);
            else
                w_new_speed = 3'd1;
        end
        w_speed_ext = (X_WIDTH+1)'(w_new_speed);
    end

    // Next-state for position, speed, tick counter and direction history.
    always_comb begin
        w_x_cand     = {1'b0, r_x};
        w_speed_next = 3'd0;
        w_tick_next  = '0;
        w_dir_next   = DIR_NONE;
        case (w_gs)
            GS_IDLE: begin
                w_x_cand = w_center;
            end
            GS_PLAY: begin
                if (!mode) begin
                    if (in_enable)
                        w_x_cand = {1'b0, abs_x};
                end else begin
                    w_speed_next = r_speed;
                    w_dir_next   = r_dir;
                    w_tick_next  = w_tick ? '0 : (r_tick + TW'(1));
                    if (w_tick) begin
                        if (w_req_dir == DIR_NONE) begin
                            w_speed_next = 3'd0;
                            w_dir_next   = DIR_NONE;
                        end else begin
                            w_speed_next = w_new_speed;
                            w_dir_next   = w_req_dir;
                            if (w_req_dir == DIR_RIGHT)
                                w_x_cand = {1'b0, r_x} + w_speed_ext;
                            else if ({1'b0, r_x} < w_speed_ext)
                                w_x_cand = '0;
                            else
                                w_x_cand = {1'b0, r_x} - w_speed_ext;
                        end
                    end
                end
            end
            default: begin
                w_x_cand = {1'b0, r_x};
            end
        endcase
        w_x_clamped = (w_x_cand > w_x_max) ? w_x_max : w_x_cand;
        w_x_next    = w_x_clamped[X_WIDTH-1:0];
    end

    // State registers with asynchronous reset to the centred default paddle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x     <= RST_X;
            r_len   <= DEF_L;
            r_speed <= 3'd0;
            r_tick  <= '0;
            r_dir   <= DIR_NONE;
            r_moved <= 1'b0;
        end else begin
            r_x     <= w_x_next;
            r_len   <= w_len_next;
            r_speed <= w_speed_next;
            r_tick  <= w_tick_next;
            r_dir   <= w_dir_next;
            r_moved <= (w_x_next != r_x);
        end
    end

    // Wall flags decode straight from the registered position and length.
    always_comb begin
        at_left  = (r_x == '0);
        at_right = ({1'b0, r_x} == (SCREEN_X - {1'b0, r_len}));
    end

    assign paddle_x   = r_x;
    assign paddle_len = r_len;
    assign speed      = r_speed;
    assign moved      = r_moved;

endmodule
